// File: rtl/branch_unit.sv
// Two-stage branch/jump resolution unit: S1 holds operands and compare flags, S2 holds the
// resolved outcome driven on out_*. Define BRANCH_STATS_EN to build the consumption counters.

module comparator #(
  parameter int unsigned W = 64
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic         gt,
  output logic         lt,
  output logic         eq
);
  assign gt = a > b;
  assign lt = a < b;
  assign eq = a == b;
endmodule

module branch_unit #(
  parameter int unsigned XLEN = 64
`ifdef BRANCH_STATS_EN
  ,
  parameter int unsigned CNT_W = 32
`endif
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [2:0]      in_funct3,
  input  logic            in_is_jal,
  input  logic            in_is_jalr,
  input  logic [XLEN-1:0] in_rs1,
  input  logic [XLEN-1:0] in_rs2,
  input  logic [XLEN-1:0] in_pc,
  input  logic [XLEN-1:0] in_imm,
  input  logic            in_pred_taken,
  output logic            out_valid,
  input  logic            out_ready,
  output logic            out_taken,
  output logic [XLEN-1:0] out_target,
  output logic [XLEN-1:0] out_link,
  output logic            out_redirect,
  output logic            out_misalign,
  output logic            out_illegal
`ifdef BRANCH_STATS_EN
  ,
  output logic [CNT_W-1:0] stat_branches,
  output logic [CNT_W-1:0] stat_taken,
  output logic [CNT_W-1:0] stat_redirects
`endif
);

  localparam logic [XLEN-1:0] MsbMask = {1'b1, {(XLEN - 1){1'b0}}};

  logic s1_valid, s2_valid;
  logic s1_ready, s2_ready;
  logic s1_load, s2_load;

  assign s2_ready = !s2_valid || out_ready;
  assign s1_ready = !s1_valid || s2_ready;
  assign in_ready = !rst && !flush && s1_ready;
  assign s1_load  = in_valid && in_ready;
  assign s2_load  = s1_valid && s2_ready;
  assign out_valid = s2_valid;

  // Signed compare reuses the unsigned comparator with both sign bits flipped.
  logic [XLEN-1:0] rs1_flip, rs2_flip, sum_base, sum;
  logic            cu_gt, cu_lt, cu_eq, cs_gt, cs_lt, cs_eq;

  assign rs1_flip = in_rs1 ^ MsbMask;
  assign rs2_flip = in_rs2 ^ MsbMask;
  assign sum_base = in_is_jalr ? in_rs1 : in_pc;
  assign sum      = sum_base + in_imm;

  comparator #(.W(XLEN)) u_cmp_u (
    .a (in_rs1),
    .b (in_rs2),
    .gt(cu_gt),
    .lt(cu_lt),
    .eq(cu_eq)
  );

  comparator #(.W(XLEN)) u_cmp_s (
    .a (rs1_flip),
    .b (rs2_flip),
    .gt(cs_gt),
    .lt(cs_lt),
    .eq(cs_eq)
  );

  // S1 registers
  logic [2:0]      s1_funct3;
  logic            s1_jal, s1_jalr, s1_pred;
  logic [XLEN-1:0] s1_pc, s1_sum;
  logic            s1_gt_u, s1_lt_u, s1_eq_u, s1_gt_s, s1_lt_s, s1_eq_s;

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      s1_valid <= 1'b0;
      s2_valid <= 1'b0;
    end else begin
      if (s1_ready) s1_valid <= s1_load;
      if (s2_ready) s2_valid <= s1_valid;
    end
  end

  always_ff @(posedge clk) begin
    if (s1_load) begin
      s1_funct3 <= in_funct3;
      s1_jal    <= in_is_jal;
      s1_jalr   <= in_is_jalr;
      s1_pred   <= in_pred_taken;
      s1_pc     <= in_pc;
      s1_sum    <= sum;
      s1_gt_u   <= cu_gt;
      s1_lt_u   <= cu_lt;
      s1_eq_u   <= cu_eq;
      s1_gt_s   <= cs_gt;
      s1_lt_s   <= cs_lt;
      s1_eq_s   <= cs_eq;
    end
  end

  // Resolution from S1 state
  logic            cond_taken, is_cond;
  logic            res_taken, res_illegal, res_misalign, res_redirect;
  logic [XLEN-1:0] jump_target, res_link, res_target;

  always_comb begin
    cond_taken = 1'b0;
    case (s1_funct3)
      3'b000:  cond_taken = s1_eq_u;
      3'b001:  cond_taken = !s1_eq_u;
      3'b100:  cond_taken = s1_lt_s;
      3'b101:  cond_taken = s1_gt_s || s1_eq_s;
      3'b110:  cond_taken = s1_lt_u;
      3'b111:  cond_taken = s1_gt_u || s1_eq_u;
      default: cond_taken = 1'b0;
    endcase
  end

  assign is_cond      = !(s1_jal || s1_jalr);
  assign res_illegal  = is_cond && (s1_funct3[2:1] == 2'b01);
  assign res_taken    = !is_cond || cond_taken;
  assign jump_target  = s1_jalr ? {s1_sum[XLEN-1:1], 1'b0} : s1_sum;
  assign res_link     = s1_pc + XLEN'(4);
  assign res_target   = res_taken ? jump_target : res_link;
  assign res_misalign = res_taken && (jump_target[1:0] != 2'b00);
  assign res_redirect = (res_taken != s1_pred) && !res_misalign && !res_illegal;

  // S2 registers; only loaded while the output is free or draining, so stalls hold data.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_taken    <= 1'b0;
      out_target   <= '0;
      out_link     <= '0;
      out_redirect <= 1'b0;
      out_misalign <= 1'b0;
      out_illegal  <= 1'b0;
    end else if (s2_load) begin
      out_taken    <= res_taken;
      out_target   <= res_target;
      out_link     <= res_link;
      out_redirect <= res_redirect;
      out_misalign <= res_misalign;
      out_illegal  <= res_illegal;
    end
  end

`ifdef BRANCH_STATS_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      stat_branches  <= '0;
      stat_taken     <= '0;
      stat_redirects <= '0;
    end else if (out_valid && out_ready) begin
      stat_branches  <= stat_branches + CNT_W'(1);
      stat_taken     <= stat_taken + CNT_W'(out_taken);
      stat_redirects <= stat_redirects + CNT_W'(out_redirect);
    end
  end
`endif

endmodule

// File: tb/tb_branch_unit.sv
// Bench for branch_unit: directed cases plus randomized traffic against a queue-based model.
// Counter checks are built when BRANCH_STATS_EN is defined.

module tb_branch_unit;

  logic        clk = 1'b0;
  logic        rst, flush, in_valid, in_ready, in_is_jal, in_is_jalr, in_pred_taken;
  logic [2:0]  in_funct3;
  logic [63:0] in_rs1, in_rs2, in_pc, in_imm;
  logic        out_valid, out_ready, out_taken, out_redirect, out_misalign, out_illegal;
  logic [63:0] out_target, out_link;
`ifdef BRANCH_STATS_EN
  logic [31:0] stat_branches, stat_taken, stat_redirects;
`endif

  always #5 clk = ~clk;

  branch_unit dut (
    .clk          (clk),
    .rst          (rst),
    .flush        (flush),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_funct3    (in_funct3),
    .in_is_jal    (in_is_jal),
    .in_is_jalr   (in_is_jalr),
    .in_rs1       (in_rs1),
    .in_rs2       (in_rs2),
    .in_pc        (in_pc),
    .in_imm       (in_imm),
    .in_pred_taken(in_pred_taken),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_taken    (out_taken),
    .out_target   (out_target),
    .out_link     (out_link),
    .out_redirect (out_redirect),
    .out_misalign (out_misalign),
    .out_illegal  (out_illegal)
`ifdef BRANCH_STATS_EN
    ,
    .stat_branches (stat_branches),
    .stat_taken    (stat_taken),
    .stat_redirects(stat_redirects)
`endif
  );

  typedef struct packed {
    logic        taken;
    logic [63:0] target;
    logic [63:0] link;
    logic        redirect;
    logic        misalign;
    logic        illegal;
  } res_t;

  res_t sb[$];
  int   n_checks = 0;
  int   n_errors = 0;
  int   n_consumed = 0;
  int   exp_br = 0, exp_tk = 0, exp_rd = 0;
  logic rst_q = 1'b0;
  logic saw_stall = 1'b0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%h, expected 0x%h", tag, got, exp);
    end
  endtask

  function automatic res_t model(input logic [2:0] f3, input logic jal, input logic jalr,
                                 input logic [63:0] rs1, input logic [63:0] rs2,
                                 input logic [63:0] pc, input logic [63:0] imm,
                                 input logic pred);
    res_t r;
    logic [63:0] dest;
    r = '0;
    r.link = pc + 64'd4;
    if (jal) begin
      r.taken = 1'b1;
      dest = pc + imm;
    end else if (jalr) begin
      r.taken = 1'b1;
      dest = (rs1 + imm) & ~64'd1;
    end else begin
      dest = pc + imm;
      case (f3)
        3'd0: r.taken = (rs1 == rs2);
        3'd1: r.taken = (rs1 != rs2);
        3'd4: r.taken = ($signed(rs1) < $signed(rs2));
        3'd5: r.taken = ($signed(rs1) >= $signed(rs2));
        3'd6: r.taken = (rs1 < rs2);
        3'd7: r.taken = (rs1 >= rs2);
        default: r.illegal = 1'b1;
      endcase
    end
    r.target = r.taken ? dest : r.link;
    r.misalign = r.taken && (dest[1:0] != 2'b00);
    r.redirect = (r.taken != pred) && !r.misalign && !r.illegal;
    return r;
  endfunction

  always @(posedge clk) rst_q <= rst;

  // Scoreboard: a request joins on acceptance, leaves on consumption, vanishes on flush/reset.
  always @(negedge clk) begin
    res_t e;
    if (rst_q) begin
      check_eq("rst_out_valid", out_valid, 0);
      check_eq("rst_out_taken", out_taken, 0);
      check_eq("rst_out_target", out_target, 0);
      check_eq("rst_out_link", out_link, 0);
`ifdef BRANCH_STATS_EN
      check_eq("rst_stat_branches", stat_branches, 0);
`endif
    end
    if (rst) begin
      check_eq("rst_in_ready", in_ready, 0);
      sb.delete();
      exp_br = 0;
      exp_tk = 0;
      exp_rd = 0;
    end else begin
      check_eq("in_ready", in_ready, !flush && (sb.size() < 2 || out_ready));
      if (sb.size() == 0) check_eq("out_valid_empty", out_valid, 0);
      if (sb.size() == 2) check_eq("out_valid_full", out_valid, 1);
      if (out_valid && out_ready && sb.size() > 0) begin
        e = sb.pop_front();
        n_consumed++;
        check_eq("sb_taken", out_taken, e.taken);
        check_eq("sb_target", out_target, e.target);
        check_eq("sb_link", out_link, e.link);
        check_eq("sb_redirect", out_redirect, e.redirect);
        check_eq("sb_misalign", out_misalign, e.misalign);
        check_eq("sb_illegal", out_illegal, e.illegal);
        exp_br++;
        if (e.taken) exp_tk++;
        if (e.redirect) exp_rd++;
      end
      if (flush) sb.delete();
      else if (in_valid && in_ready)
        sb.push_back(model(in_funct3, in_is_jal, in_is_jalr, in_rs1, in_rs2, in_pc, in_imm,
                           in_pred_taken));
    end
  end

  task automatic present(input logic [2:0] f3, input logic jal, input logic jalr,
                         input logic [63:0] rs1, input logic [63:0] rs2,
                         input logic [63:0] pc, input logic [63:0] imm, input logic pred);
    in_valid = 1'b1;
    in_funct3 = f3;
    in_is_jal = jal;
    in_is_jalr = jalr;
    in_rs1 = rs1;
    in_rs2 = rs2;
    in_pc = pc;
    in_imm = imm;
    in_pred_taken = pred;
  endtask

  task automatic wait_accept();
    int guard = 0;
    @(negedge clk);
    while (!in_ready && guard < 64) begin
      saw_stall = 1'b1;
      @(negedge clk);
      guard++;
    end
    if (!in_ready) check_eq("accept_timeout", in_ready, 1);
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [2:0] f3, input logic jal, input logic jalr,
                      input logic [63:0] rs1, input logic [63:0] rs2,
                      input logic [63:0] pc, input logic [63:0] imm, input logic pred);
    @(posedge clk);
    #1;
    present(f3, jal, jalr, rs1, rs2, pc, imm, pred);
    wait_accept();
    in_valid = 1'b0;
  endtask

  // Presented after edge N, the result must be visible after edge N+2 and not before.
  task automatic dir(input logic [2:0] f3, input logic jal, input logic jalr,
                     input logic [63:0] rs1, input logic [63:0] rs2,
                     input logic [63:0] pc, input logic [63:0] imm, input logic pred);
    send(f3, jal, jalr, rs1, rs2, pc, imm, pred);
    @(negedge clk);
    check_eq("lat_early", out_valid, 0);
    @(negedge clk);
    check_eq("lat_due", out_valid, 1);
  endtask

  task automatic rand_req();
    int k;
    logic [11:0] s;
    k = $urandom_range(0, 7);
    in_funct3 = 3'($urandom_range(0, 7));
    in_is_jal = (k == 0);
    in_is_jalr = (k == 1);
    in_rs1 = ($urandom_range(0, 1) == 1) ? {$urandom, $urandom}
                                         : 64'($urandom_range(0, 8)) - 64'd4;
    case ($urandom_range(0, 2))
      0: in_rs2 = in_rs1;
      1: in_rs2 = {$urandom, $urandom};
      default: in_rs2 = 64'($urandom_range(0, 8)) - 64'd4;
    endcase
    in_pc = {$urandom, $urandom} & ~64'd3;
    s = 12'($urandom);
    in_imm = {{52{s[11]}}, s};
    if ($urandom_range(0, 3) != 0) in_imm[1:0] = 2'b00;
    in_pred_taken = 1'($urandom_range(0, 1));
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int base;
    rst = 1'b1;
    flush = 1'b0;
    out_ready = 1'b0;
    present(3'b000, 1'b0, 1'b0, 64'd0, 64'd0, 64'd0, 64'd0, 1'b0);
    in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    out_ready = 1'b1;

    dir(3'b000, 1'b0, 1'b0, 64'd4, 64'd4, 64'h100, 64'h20, 1'b0);
    check_eq("beq_taken", out_taken, 1);
    check_eq("beq_target", out_target, 64'h120);
    check_eq("beq_redirect", out_redirect, 1);
    check_eq("beq_link", out_link, 64'h104);

    dir(3'b100, 1'b0, 1'b0, '1, 64'd1, 64'h200, 64'h40, 1'b0);
    check_eq("blt_taken", out_taken, 1);
    check_eq("blt_target", out_target, 64'h240);
    dir(3'b110, 1'b0, 1'b0, '1, 64'd1, 64'h200, 64'h40, 1'b0);
    check_eq("bltu_taken", out_taken, 0);
    check_eq("bltu_target", out_target, 64'h204);
    dir(3'b111, 1'b0, 1'b0, '1, 64'd1, 64'h200, 64'h40, 1'b0);
    check_eq("bgeu_taken", out_taken, 1);

    dir(3'b000, 1'b0, 1'b1, 64'h1001, 64'd0, 64'h300, 64'h10, 1'b0);
    check_eq("jalr_target", out_target, 64'h1010);
    check_eq("jalr_link", out_link, 64'h304);
    dir(3'b000, 1'b1, 1'b0, 64'd0, 64'd0, 64'h300, 64'h6, 1'b0);
    check_eq("jal_misalign", out_misalign, 1);
    check_eq("jal_redirect", out_redirect, 0);

    dir(3'b010, 1'b0, 1'b0, 64'd5, 64'd5, 64'h500, 64'h20, 1'b1);
    check_eq("ill_illegal", out_illegal, 1);
    check_eq("ill_taken", out_taken, 0);
    check_eq("ill_redirect", out_redirect, 0);

    dir(3'b000, 1'b1, 1'b0, 64'd0, 64'd0, 64'hFFFF_FFFF_FFFF_FFFC, 64'd8, 1'b1);
    check_eq("wrap_target", out_target, 64'h4);
    check_eq("wrap_link", out_link, 64'h0);

    // Back-to-back stream of 8 with the consumer stalled for cycles 3-5.
    repeat (3) @(posedge clk);
    #1;
    saw_stall = 1'b0;
    base = n_consumed;
    fork
      begin
        for (int c = 0; c < 20; c++) begin
          out_ready = !(c >= 3 && c <= 5);
          @(posedge clk);
          #1;
        end
      end
      begin
        for (int i = 0; i < 8; i++) begin
          present((i % 2 == 0) ? 3'b000 : 3'b110, 1'b0, 1'b0, 64'(i), 64'(i % 3),
                  64'h1000 + 64'(8 * i), 64'h40, 1'(i % 2));
          wait_accept();
        end
        in_valid = 1'b0;
      end
    join
    check_eq("stream_stall", saw_stall, 1);
    check_eq("stream_count", n_consumed - base, 8);

    // Flush with both stages full; the request offered alongside must vanish.
    out_ready = 1'b0;
    send(3'b000, 1'b0, 1'b0, 64'd1, 64'd1, 64'h2000, 64'h8, 1'b0);
    send(3'b001, 1'b0, 1'b0, 64'd1, 64'd1, 64'h2100, 64'h8, 1'b0);
    @(posedge clk);
    #1;
    flush = 1'b1;
    present(3'b000, 1'b1, 1'b0, 64'd0, 64'd0, 64'hDEAD0, 64'h8, 1'b0);
    @(negedge clk);
    check_eq("flush_in_ready", in_ready, 0);
    @(posedge clk);
    #1;
    flush = 1'b0;
    in_valid = 1'b0;
    @(negedge clk);
    check_eq("flush_out_valid", out_valid, 0);
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    repeat (4) begin
      @(negedge clk);
      check_eq("flush_dropped", out_valid, 0);
    end

    for (int c = 0; c < 3000; c++) begin
      @(posedge clk);
      #1;
      flush = ($urandom_range(0, 49) == 0);
      out_ready = ($urandom_range(0, 3) != 0);
      in_valid = ($urandom_range(0, 3) != 0);
      rand_req();
    end
    @(posedge clk);
    #1;
    flush = 1'b0;
    in_valid = 1'b0;
    out_ready = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    check_eq("drain_empty", sb.size(), 0);
`ifdef BRANCH_STATS_EN
    check_eq("stat_branches_model", stat_branches, exp_br);
    check_eq("stat_taken_model", stat_taken, exp_tk);
    check_eq("stat_redirects_model", stat_redirects, exp_rd);

    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    send(3'b000, 1'b0, 1'b0, 64'd1, 64'd1, 64'h400, 64'h10, 1'b1);
    send(3'b001, 1'b0, 1'b0, 64'd1, 64'd2, 64'h400, 64'h10, 1'b1);
    send(3'b110, 1'b0, 1'b0, 64'd1, 64'd2, 64'h400, 64'h10, 1'b0);
    send(3'b000, 1'b0, 1'b0, 64'd1, 64'd2, 64'h400, 64'h10, 1'b0);
    send(3'b000, 1'b0, 1'b0, 64'd1, 64'd2, 64'h400, 64'h10, 1'b1);
    repeat (4) @(posedge clk);
    #1;
    check_eq("stat_branches_5", stat_branches, 5);
    check_eq("stat_taken_3", stat_taken, 3);
    check_eq("stat_redirects_2", stat_redirects, 2);
    rst = 1'b1;
    @(posedge clk);
    #1;
    check_eq("stat_rst_branches", stat_branches, 0);
    check_eq("stat_rst_taken", stat_taken, 0);
    check_eq("stat_rst_redirects", stat_redirects, 0);
    rst = 1'b0;
    repeat (2) @(posedge clk);
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
